// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared FSM encoding, RV32 R-type field constants and ALU control codes
package control_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Codes shared with the ALU; changing one here changes the datapath contract.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// rtl/control_sequencer_instr_decoder.sv - combinational RV32 R-type decoder: fields, ALU control and legality
module instr_decoder
    import control_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [3:0]  alu_ctrl,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_BASE) begin
                legal = 1'b1;
                unique case (funct3)
                    F3_ADD_SUB: alu_ctrl = ALU_ADD;
                    F3_SLL:     alu_ctrl = ALU_SLL;
                    F3_SLT:     alu_ctrl = ALU_SLT;
                    F3_SLTU:    alu_ctrl = ALU_SLTU;
                    F3_XOR:     alu_ctrl = ALU_XOR;
                    F3_SRL_SRA: alu_ctrl = ALU_SRL;
                    F3_OR:      alu_ctrl = ALU_OR;
                    F3_AND:     alu_ctrl = ALU_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                // Only SUB and SRA use the alternate funct7.
                if (funct3 == F3_ADD_SUB) begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_SUB;
                end else if (funct3 == F3_SRL_SRA) begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_SRA;
                end
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - four-state IDLE/DECODE/EXECUTE/WRITEBACK control FSM with retire counter
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             zero_flag,
    output logic [4:0]       mem_read_addr_1,
    output logic [4:0]       mem_read_addr_2,
    output logic [4:0]       mem_write_addr,
    output logic [3:0]       alu_ctrl,
    output logic             r_or_w,
    output logic             done,
    output logic             illegal,
    output logic             zero_q,
    output logic [CNT_W-1:0] retired
);

    state_t      state;
    logic [31:0] ir;
    logic [31:0] dec_word;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [3:0]  dec_alu;
    logic        dec_legal;

    // In IDLE the decoder looks at the incoming word so the datapath outputs
    // and the illegal pulse can be registered on the capture edge.
    assign dec_word    = (state == S_IDLE) ? instr : ir;
    assign instr_ready = (state == S_IDLE) && !reset;

    instr_decoder u_decoder (
        .instr    (dec_word),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            ir              <= '0;
            mem_read_addr_1 <= '0;
            mem_read_addr_2 <= '0;
            mem_write_addr  <= '0;
            alu_ctrl        <= '0;
            r_or_w          <= 1'b0;
            done            <= 1'b0;
            illegal         <= 1'b0;
            zero_q          <= 1'b0;
            retired         <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            r_or_w  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir              <= instr;
                        mem_read_addr_1 <= dec_rs1;
                        mem_read_addr_2 <= dec_rs2;
                        mem_write_addr  <= dec_rd;
                        alu_ctrl        <= dec_alu;
                        illegal         <= !dec_legal;
                        state           <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        state <= S_EXECUTE;
                    end else begin
                        mem_read_addr_1 <= '0;
                        mem_read_addr_2 <= '0;
                        mem_write_addr  <= '0;
                        alu_ctrl        <= '0;
                        state           <= S_IDLE;
                    end
                end
                S_EXECUTE: begin
                    zero_q <= zero_flag;
                    r_or_w <= (mem_write_addr != 5'd0);
                    done   <= 1'b1;
                    state  <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    retired         <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                    mem_read_addr_1 <= '0;
                    mem_read_addr_2 <= '0;
                    mem_write_addr  <= '0;
                    alu_ctrl        <= '0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed scoreboard bench for control_sequencer
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        zero_flag;
    logic        instr_ready;
    logic [4:0]  mem_read_addr_1, mem_read_addr_2, mem_write_addr;
    logic [3:0]  alu_ctrl;
    logic        r_or_w, done, illegal, zero_q;
    logic [31:0] retired;

    logic        w_instr_ready;
    logic [4:0]  w_ra1, w_ra2, w_wa;
    logic [3:0]  w_alu;
    logic        w_r_or_w, w_done, w_illegal, w_zero_q;
    logic [1:0]  w_retired;

    typedef struct {
        string      tag;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu;
        logic       wr;
        logic       zq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_ret = 0;

    always #5 clk = ~clk;

    control_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .zero_flag(zero_flag),
        .mem_read_addr_1(mem_read_addr_1), .mem_read_addr_2(mem_read_addr_2),
        .mem_write_addr(mem_write_addr), .alu_ctrl(alu_ctrl), .r_or_w(r_or_w),
        .done(done), .illegal(illegal), .zero_q(zero_q), .retired(retired)
    );

    control_sequencer #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(w_instr_ready), .zero_flag(zero_flag),
        .mem_read_addr_1(w_ra1), .mem_read_addr_2(w_ra2),
        .mem_write_addr(w_wa), .alu_ctrl(w_alu), .r_or_w(w_r_or_w),
        .done(w_done), .illegal(w_illegal), .zero_q(w_zero_q), .retired(w_retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic run_legal(input string tag, input logic [31:0] w, input logic zf,
                             input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                             input logic [4:0] e_rd, input logic [3:0] e_alu, input logic e_wr);
        exp_t e;
        exp_t got;
        int   lat;
        e.tag = tag; e.rs1 = e_rs1; e.rs2 = e_rs2; e.rd = e_rd;
        e.alu = e_alu; e.wr = e_wr; e.zq = zf;
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, instr_ready}, 32'd1);
        instr = w; instr_valid = 1'b1; zero_flag = zf;
        sb.push_back(e);
        @(negedge clk);
        lat = 1;
        check({tag, "_ready_busy"}, {31'd0, instr_ready}, 32'd0);
        check({tag, "_illegal_dec"}, {31'd0, illegal}, 32'd0);
        check({tag, "_rs1_dec"}, {27'd0, mem_read_addr_1}, {27'd0, e_rs1});
        check({tag, "_alu_dec"}, {28'd0, alu_ctrl}, {28'd0, e_alu});
        check({tag, "_rw_dec"}, {31'd0, r_or_w}, 32'd0);
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (!done) check({tag, "_rw_pre"}, {31'd0, r_or_w}, 32'd0);
        end
        check({tag, "_latency"}, lat, 32'd3);
        if (done && sb.size() > 0) begin
            got = sb.pop_front();
            check({got.tag, "_rs1"}, {27'd0, mem_read_addr_1}, {27'd0, got.rs1});
            check({got.tag, "_rs2"}, {27'd0, mem_read_addr_2}, {27'd0, got.rs2});
            check({got.tag, "_rd"}, {27'd0, mem_write_addr}, {27'd0, got.rd});
            check({got.tag, "_alu"}, {28'd0, alu_ctrl}, {28'd0, got.alu});
            check({got.tag, "_r_or_w"}, {31'd0, r_or_w}, {31'd0, got.wr});
            check({got.tag, "_zero_q"}, {31'd0, zero_q}, {31'd0, got.zq});
            check({got.tag, "_no_illegal"}, {31'd0, illegal}, 32'd0);
        end
        instr_valid = 1'b0;
        zero_flag = ~zf;
        @(negedge clk);
        exp_ret++;
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_retired_w2"}, {30'd0, w_retired}, exp_ret % 4);
        check({tag, "_ready_after"}, {31'd0, instr_ready}, 32'd1);
        check({tag, "_done_after"}, {31'd0, done}, 32'd0);
        check({tag, "_rw_after"}, {31'd0, r_or_w}, 32'd0);
        check({tag, "_wa_idle"}, {27'd0, mem_write_addr}, 32'd0);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] w);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, instr_ready}, 32'd1);
        instr = w; instr_valid = 1'b1;
        @(negedge clk);
        check({tag, "_illegal"}, {31'd0, illegal}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rw"}, {31'd0, r_or_w}, 32'd0);
        check({tag, "_ready_busy"}, {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;
        @(negedge clk);
        check({tag, "_illegal_drop"}, {31'd0, illegal}, 32'd0);
        check({tag, "_done_after"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, instr_ready}, 32'd1);
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instr = '0; instr_valid = 1'b0; zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_rw", {31'd0, r_or_w}, 32'd0);
        check("rst_addrs", {17'd0, mem_read_addr_1, mem_read_addr_2, mem_write_addr}, 32'd0);
        check("rst_alu", {28'd0, alu_ctrl}, 32'd0);
        check("rst_zero_q", {31'd0, zero_q}, 32'd0);
        check("rst_retired", retired, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, instr_ready}, 32'd1);

        // Abort an instruction while it sits in EXECUTE.
        @(negedge clk);
        instr = 32'h002081B3; instr_valid = 1'b1; zero_flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rw", {31'd0, r_or_w}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_wa", {27'd0, mem_write_addr}, 32'd0);
        @(negedge clk);
        check("abort_rw_hold", {31'd0, r_or_w}, 32'd0);
        check("abort_zero_q", {31'd0, zero_q}, 32'd0);
        instr_valid = 1'b0; zero_flag = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        check("abort_retired", retired, 32'd0);
        check("abort_done_after", {31'd0, done}, 32'd0);
        check("abort_rw_after", {31'd0, r_or_w}, 32'd0);

        run_legal("add_x3", 32'h002081B3, 1'b0, 5'd1, 5'd2, 5'd3, 4'b0010, 1'b1);
        run_legal("sub_x5", 32'h407302B3, 1'b1, 5'd6, 5'd7, 5'd5, 4'b0110, 1'b1);
        run_legal("add_x0", 32'h00208033, 1'b0, 5'd1, 5'd2, 5'd0, 4'b0010, 1'b0);
        run_illegal("addi", 32'h00000013);
        run_illegal("sll_alt", rtype(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd4));
        run_legal("sra_x8", rtype(7'b0100000, 5'd10, 5'd9, 3'b101, 5'd8), 1'b1,
                  5'd9, 5'd10, 5'd8, 4'b1000, 1'b1);
        run_legal("xor_x12", rtype(7'b0000000, 5'd31, 5'd17, 3'b100, 5'd12), 1'b0,
                  5'd17, 5'd31, 5'd12, 4'b0011, 1'b1);
        run_legal("sltu_x1", rtype(7'b0000000, 5'd4, 5'd3, 3'b011, 5'd1), 1'b0,
                  5'd3, 5'd4, 5'd1, 4'b1001, 1'b1);

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: instr  input  32  RV32 instruction word offered for execution.
REQ-005 SHALL have port: instr_valid  input  1  instr is valid this cycle.
REQ-006 SHALL have port: instr_ready  output  1  sequencer accepts instr this cycle.
REQ-007 SHALL have port: zero_flag  input  1  datapath ALU zero result.
REQ-008 SHALL have ports to the datapath: mem_read_addr_1 output 5 (rs1); mem_read_addr_2 output 5 (rs2); mem_write_addr output 5 (rd); alu_ctrl output 4; r_or_w output 1 (1 = register write).
REQ-009 SHALL have ports: done output 1 retire pulse; illegal output 1 reject pulse; zero_q output 1 zero_flag of last executed instruction; retired output CNT_W retire count.

Function
REQ-010 SHALL implement FSM states IDLE, DECODE, EXECUTE, WRITEBACK.
REQ-011 IDLE: instr_ready=1; on instr_valid&&instr_ready capture instr into instruction register, go to DECODE; else stay.
REQ-012 instr_ready SHALL be 0 in every state except IDLE; instr is ignored when not ready.
REQ-013 DECODE: legal iff opcode=0110011 and (funct7=0000000, or funct7=0100000 with funct3 000/101); legal -> EXECUTE; illegal -> illegal=1 for this cycle, return to IDLE, no write, retired unchanged.
REQ-014 alu_ctrl mapping: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 1000, SLT 0111, SLTU 1001.
REQ-015 mem_read_addr_1/2, mem_write_addr, alu_ctrl SHALL be driven from the instruction register fields in DECODE, EXECUTE and WRITEBACK, stable throughout; 0 in IDLE.
REQ-016 EXECUTE: r_or_w=0; zero_q loads zero_flag at end of cycle; go to WRITEBACK.
REQ-017 WRITEBACK: r_or_w=1 for exactly this cycle unless rd=0 (then r_or_w=0); done=1; retired+=1; go to IDLE.
REQ-018 r_or_w SHALL be 0 in all states except WRITEBACK.
REQ-019 Latency: handshake at edge N -> done high in cycle N+3; next accept no earlier than cycle N+4 (one instruction per 4 cycles max).
REQ-020 retired SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-021 done and illegal SHALL never be high together.

Reset
REQ-022 reset SHALL force IDLE, instruction register 0, all datapath outputs 0, r_or_w=0, done=0, illegal=0, zero_q=0, retired=0, instr_ready=0 while asserted.
REQ-023 reset asserted mid-instruction SHALL abort it: no write, no done, no count; instr_ready=1 first cycle after deassertion.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, opcode/funct constants and the alu_ctrl codes (shared with the ALU).
REQ-025 One sub-module, instr_decoder (combinational: instruction -> rs1, rs2, rd, alu_ctrl, legal), SHALL be used; FSM, registers and counter stay in control_sequencer.

Verification
REQ-026 Reset mid-EXECUTE -> r_or_w never 1, retired=0, instr_ready=1 after release.
REQ-027 instr=0x002081B3 (add x3,x1,x2) valid -> addrs 1/2/3, alu_ctrl=0010, r_or_w=1 and done=1 at N+3, retired=1.
REQ-028 instr=0x407302B3 (sub x5,x6,x7), zero_flag=1 in EXECUTE -> alu_ctrl=0110, zero_q=1, write to x5.
REQ-029 instr=0x00208033 (add x0,x1,x2) -> done=1, r_or_w stays 0, retired increments.
REQ-030 instr=0x00000013 (addi) -> illegal=1 at N+1, no done, no write; instr_valid held during busy cycles -> no re-capture.
REQ-031 Preload retired=0xFFFFFFFF via 2^32-1 retires (or forced), retire one more -> retired=0.
